// File: rtl/uart_rx_frame_router.sv
// Parses HEADER/LEN/payload frames from the UART receiver and routes payload bytes
// to two TX channels through a shared tagged FIFO. Optional macro: CHECKSUM_EN.
module uart_rx_frame_router #(
   parameter int         FIFO_DEPTH     = 16,
   parameter int         TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0] CMD_CH1        = 8'hC1,
   parameter logic [7:0] CMD_CH2        = 8'hC2,
   parameter logic [7:0] CMD_BOTH       = 8'hC3
) (
`ifdef CHECKSUM_EN
   output logic       chk_ok,
`endif
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic [7:0] tx1_data,
   output logic       tx1_valid,
   input  logic       tx1_ready,
   output logic [7:0] tx2_data,
   output logic       tx2_valid,
   input  logic       tx2_ready,
   input  logic       err_clr,
   output logic       overflow,
   output logic       frame_err,
   output logic       led_command,
   output logic       led_data
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LEN     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_CHK     = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      mask_q, mask_d;
   logic [7:0]      remaining_q, remaining_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            sent1_q, sent1_d;
   logic            sent2_q, sent2_d;
   logic            overflow_q, overflow_d;
   logic            frame_err_q, frame_err_d;
`ifdef CHECKSUM_EN
   logic [7:0]      chk_q, chk_d;
   logic            chk_ok_q, chk_ok_d;
`endif

   // Each entry is {mask[1:0], data[7:0]}; mask bit 0 selects TX1, bit 1 selects TX2.
   logic [9:0]      mem_q [FIFO_DEPTH];

   logic            empty_s, full_s, pop_s, push_s, push_req_s;
   logic            v1_s, v2_s, hs1_s, hs2_s, done1_s, done2_s;
   logic            timeout_s, fe_set_s, ov_set_s;
   logic [9:0]      head_s;

   // FIFO head view and the per-channel handshake / pop decision.
   always_comb begin
      empty_s = (count_q == '0);
      full_s  = (count_q == CW'(FIFO_DEPTH));
      head_s  = mem_q[rd_ptr_q];
      v1_s    = !empty_s && head_s[8] && !sent1_q;
      v2_s    = !empty_s && head_s[9] && !sent2_q;
      hs1_s   = v1_s && tx1_ready;
      hs2_s   = v2_s && tx2_ready;
      done1_s = !head_s[8] || sent1_q || hs1_s;
      done2_s = !head_s[9] || sent2_q || hs2_s;
      pop_s   = !empty_s && done1_s && done2_s;
   end

   // Parser next state, timeout, FIFO bookkeeping and sticky flags.
   always_comb begin
      state_d     = state_q;
      mask_d      = mask_q;
      remaining_d = remaining_q;
      push_req_s  = 1'b0;
      fe_set_s    = 1'b0;
`ifdef CHECKSUM_EN
      chk_d       = chk_q;
      chk_ok_d    = 1'b0;
`endif
      timeout_s = (state_q != S_IDLE) && !rx_valid && (timer_q == TW'(TIMEOUT_CYCLES - 1));
      if (rx_valid || state_q == S_IDLE) begin
         timer_d = '0;
      end else begin
         timer_d = timer_q + TW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               if (rx_data == CMD_CH1) begin
                  mask_d  = 2'b01;
                  state_d = S_LEN;
               end else if (rx_data == CMD_CH2) begin
                  mask_d  = 2'b10;
                  state_d = S_LEN;
               end else if (rx_data == CMD_BOTH) begin
                  mask_d  = 2'b11;
                  state_d = S_LEN;
               end else begin
                  fe_set_s = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_LEN: begin
            if (rx_valid) begin
               if (rx_data == 8'd0) begin
                  state_d = S_IDLE;
               end else begin
                  remaining_d = rx_data;
                  state_d     = S_PAYLOAD;
`ifdef CHECKSUM_EN
                  chk_d       = rx_data;
`endif
               end
            end else if (timeout_s) begin
               state_d  = S_IDLE;
               fe_set_s = 1'b1;
            end else begin
               state_d = S_LEN;
            end
         end
         S_PAYLOAD: begin
            if (rx_valid) begin
               push_req_s  = 1'b1;
               remaining_d = remaining_q - 8'd1;
`ifdef CHECKSUM_EN
               chk_d       = chk_q ^ rx_data;
               if (remaining_q == 8'd1) begin
                  state_d = S_CHK;
               end else begin
                  state_d = S_PAYLOAD;
               end
`else
               if (remaining_q == 8'd1) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_PAYLOAD;
               end
`endif
            end else if (timeout_s) begin
               state_d  = S_IDLE;
               fe_set_s = 1'b1;
            end else begin
               state_d = S_PAYLOAD;
            end
         end
`ifdef CHECKSUM_EN
         S_CHK: begin
            if (rx_valid) begin
               state_d = S_IDLE;
               if (rx_data == chk_q) begin
                  chk_ok_d = 1'b1;
               end else begin
                  fe_set_s = 1'b1;
               end
            end else if (timeout_s) begin
               state_d  = S_IDLE;
               fe_set_s = 1'b1;
            end else begin
               state_d = S_CHK;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A full FIFO still accepts when the head leaves in the same cycle.
      push_s   = push_req_s && (!full_s || pop_s);
      ov_set_s = push_req_s && !push_s;

      wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
      rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      sent1_d = pop_s ? 1'b0 : (sent1_q || hs1_s);
      sent2_d = pop_s ? 1'b0 : (sent2_q || hs2_s);

      overflow_d  = ov_set_s ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
      frame_err_d = fe_set_s ? 1'b1 : (err_clr ? 1'b0 : frame_err_q);
   end

   // State and control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         mask_q      <= 2'b00;
         remaining_q <= 8'd0;
         timer_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sent1_q     <= 1'b0;
         sent2_q     <= 1'b0;
         overflow_q  <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef CHECKSUM_EN
         chk_q       <= 8'd0;
         chk_ok_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mask_q      <= mask_d;
         remaining_q <= remaining_d;
         timer_q     <= timer_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sent1_q     <= sent1_d;
         sent2_q     <= sent2_d;
         overflow_q  <= overflow_d;
         frame_err_q <= frame_err_d;
`ifdef CHECKSUM_EN
         chk_q       <= chk_d;
         chk_ok_q    <= chk_ok_d;
`endif
      end
   end

   // Payload storage; contents are only observed through the count-qualified head.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= {mask_q, rx_data};
      end
   end

   assign tx1_valid   = v1_s;
   assign tx2_valid   = v2_s;
   assign tx1_data    = empty_s ? 8'h00 : head_s[7:0];
   assign tx2_data    = empty_s ? 8'h00 : head_s[7:0];
   assign overflow    = overflow_q;
   assign frame_err   = frame_err_q;
   assign led_command = (state_q != S_IDLE);
   assign led_data    = !empty_s;
`ifdef CHECKSUM_EN
   assign chk_ok      = chk_ok_q;
`endif

endmodule
